// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates two writeback sources (req0 = ALU, req1 = load unit) onto the
//   single write port of a register file. It also keeps a per-register
//   pending-write scoreboard and a saturating count of contested cycles.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   req{0,1}_valid/addr/data writeback requests
//   req{0,1}_ready           combinational grant (transfer on valid && ready)
//   claim_valid, claim_addr  decode reserves a destination register
//   busy_vec                 registered pending-write bit per register
//   WE3, AD3, WD3            registered register-file write port
//   conflict_cnt             saturating count of cycles with both requests valid
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  input  logic [ADDRESS_WIDTH-1:0]    req0_addr,
  input  logic [DATA_WIDTH-1:0]       req0_data,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [ADDRESS_WIDTH-1:0]    req1_addr,
  input  logic [DATA_WIDTH-1:0]       req1_data,
  output logic                        req1_ready,
  input  logic                        claim_valid,
  input  logic [ADDRESS_WIDTH-1:0]    claim_addr,
  output logic [2**ADDRESS_WIDTH-1:0] busy_vec,
  output logic                        WE3,
  output logic [ADDRESS_WIDTH-1:0]    AD3,
  output logic [DATA_WIDTH-1:0]       WD3,
  output logic [15:0]                 conflict_cnt
);

  localparam int NREGS = 2**ADDRESS_WIDTH;

  // Index of the requester granted most recently. Reset value 1 lets req0
  // win the first contested cycle.
  logic                     last_grant;
  logic                     xfer;
  logic                     contested;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [NREGS-1:0]         busy_next;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  assign contested = req0_valid && req1_valid;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (contested) begin
      req0_ready = last_grant;
      req1_ready = !last_grant;
    end else begin
      req0_ready = req0_valid;
      req1_ready = req1_valid;
    end
  end

  assign xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel_addr = req1_ready ? req1_addr : req0_addr;
  assign sel_data = req1_ready ? req1_data : req0_data;

  // Clear for the write completing this cycle first, so a claim landing on
  // the same register at the same edge takes priority.
  always_comb begin
    busy_next = busy_vec;
    if (WE3) busy_next[AD3] = 1'b0;
    if (claim_valid && (claim_addr != '0)) busy_next[claim_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Arbitration stage -> register-file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      WE3        <= 1'b0;
      AD3        <= '0;
      WD3        <= '0;
    end else begin
      WE3 <= xfer && (sel_addr != '0);
      if (xfer) begin
        last_grant <= req1_ready;
        AD3        <= sel_addr;
        WD3        <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec     <= '0;
      conflict_cnt <= '0;
    end else begin
      busy_vec <= busy_next;
      if (contested) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic [31:0] busy_vec;
  logic        WE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;
  logic [15:0] conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .claim_valid(claim_valid), .claim_addr(claim_addr), .busy_vec(busy_vec),
    .WE3(WE3), .AD3(AD3), .WD3(WD3), .conflict_cnt(conflict_cnt)
  );

  task automatic idle_inputs();
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    claim_valid = 0; claim_addr = 0;
  endtask

  // Reset asserted and released away from the clock edge.
  task automatic do_reset();
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #3;
    n_checks++;
    if (WE3 !== 1'b0 || AD3 !== 5'd0 || WD3 !== 32'd0) begin
      n_fail++; $display("FAIL reset_wport: WE3=%b AD3=%0d WD3=%h expected 0/0/0", WE3, AD3, WD3);
    end
    n_checks++;
    if (busy_vec !== 32'd0 || conflict_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_state: busy=%h cnt=%h expected 0/0", busy_vec, conflict_cnt);
    end
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: r0=%b r1=%b expected 0/0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_single_req0();
    do_reset();
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: r0=%b r1=%b expected 1/0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (WE3 !== 1'b1 || AD3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_write: WE3=%b AD3=%0d WD3=%h expected 1/5/deadbeef", WE3, AD3, WD3);
    end
    @(posedge clk); #1;
    n_checks++;
    if (WE3 !== 1'b0 || AD3 !== 5'd5 || WD3 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL single_after: WE3=%b AD3=%0d WD3=%h expected 0/5/deadbeef (held)", WE3, AD3, WD3);
    end
  endtask

  task automatic test_contested();
    logic [4:0] exp_addr;
    do_reset();
    req0_valid = 1; req0_addr = 3; req0_data = 32'h33;
    req1_valid = 1; req1_addr = 7; req1_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL contest_grant[%0d]: r0=%b r1=%b expected %b/%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
      end
      @(posedge clk); #1;
      if (i == 3) idle_inputs();
      exp_addr = (i % 2 == 0) ? 5'd3 : 5'd7;
      n_checks++;
      if (WE3 !== 1'b1 || AD3 !== exp_addr) begin
        n_fail++; $display("FAIL contest_write[%0d]: WE3=%b AD3=%0d expected 1/%0d", i, WE3, AD3, exp_addr);
      end
    end
    n_checks++;
    if (conflict_cnt !== 16'd4) begin
      n_fail++; $display("FAIL contest_cnt: cnt=%0d expected 4", conflict_cnt);
    end
  endtask

  task automatic test_busy_clear();
    do_reset();
    claim_valid = 1; claim_addr = 9;
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (busy_vec !== 32'h200) begin
      n_fail++; $display("FAIL busy_set: busy=%h expected 00000200", busy_vec);
    end
    req1_valid = 1; req1_addr = 9; req1_data = 32'h12345678;
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (WE3 !== 1'b1 || AD3 !== 5'd9 || WD3 !== 32'h12345678 || busy_vec !== 32'h200) begin
      n_fail++; $display("FAIL busy_pending: WE3=%b AD3=%0d WD3=%h busy=%h expected 1/9/12345678/00000200", WE3, AD3, WD3, busy_vec);
    end
    @(posedge clk); #1;
    n_checks++;
    if (WE3 !== 1'b0 || busy_vec !== 32'd0) begin
      n_fail++; $display("FAIL busy_clear: WE3=%b busy=%h expected 0/0", WE3, busy_vec);
    end
  endtask

  task automatic test_claim_wins();
    do_reset();
    claim_valid = 1; claim_addr = 9;
    req0_valid = 1; req0_addr = 9; req0_data = 32'h99;
    @(posedge clk); #1;
    // WE3 now targets reg 9 while decode claims reg 9 again.
    req0_valid = 0;
    claim_valid = 1; claim_addr = 9;
    n_checks++;
    if (WE3 !== 1'b1 || AD3 !== 5'd9) begin
      n_fail++; $display("FAIL claimwin_write: WE3=%b AD3=%0d expected 1/9", WE3, AD3);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (busy_vec[9] !== 1'b1) begin
      n_fail++; $display("FAIL claimwin_busy: busy[9]=%b expected 1", busy_vec[9]);
    end
  endtask

  task automatic test_addr_zero();
    do_reset();
    req0_valid = 1; req0_addr = 0; req0_data = 32'hFFFF0000;
    claim_valid = 1; claim_addr = 0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_ready: r0=%b expected 1", req0_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (WE3 !== 1'b0 || busy_vec !== 32'd0) begin
      n_fail++; $display("FAIL zero_write: WE3=%b busy=%h expected 0/0", WE3, busy_vec);
    end
    // The zero-address transfer still moved the pointer: next contest goes to req1.
    req0_valid = 1; req0_addr = 1; req1_valid = 1; req1_addr = 2;
    #1;
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_pointer: r0=%b r1=%b expected 0/1", req0_ready, req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    req0_valid = 1; req0_addr = 5; req0_data = 32'hA5A5A5A5;
    claim_valid = 1; claim_addr = 12;
    @(posedge clk); #1;
    idle_inputs();
    #2;
    rst = 1;
    #1;
    n_checks++;
    if (WE3 !== 1'b0 || AD3 !== 5'd0 || WD3 !== 32'd0 || busy_vec !== 32'd0) begin
      n_fail++; $display("FAIL async_reset: WE3=%b AD3=%0d WD3=%h busy=%h expected all 0", WE3, AD3, WD3, busy_vec);
    end
    #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (WE3 !== 1'b0) begin
        n_fail++; $display("FAIL async_nowrite[%0d]: WE3=%b expected 0", i, WE3);
      end
    end
  endtask

  // Reference model: who won last, which registers are reserved, what the
  // register file is told to write next, and how many contested cycles.
  task automatic test_random();
    int          last_winner;
    int          winner;
    logic [31:0] m_busy;
    logic        m_we;
    logic [4:0]  m_ad;
    logic [31:0] m_wd;
    int          m_cnt;
    do_reset();
    last_winner = 1; m_busy = 0; m_we = 0; m_ad = 0; m_wd = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      req0_valid  = ($urandom_range(0, 2) != 0);
      req1_valid  = ($urandom_range(0, 2) != 0);
      req0_addr   = 5'($urandom_range(0, 31));
      req1_addr   = 5'($urandom_range(0, 31));
      req0_data   = $urandom;
      req1_data   = $urandom;
      claim_valid = ($urandom_range(0, 1) != 0);
      claim_addr  = ($urandom_range(0, 1) != 0) ? m_ad : 5'($urandom_range(0, 31));
      #1;
      if (req0_valid && req1_valid) winner = 1 - last_winner;
      else if (req0_valid) winner = 0;
      else if (req1_valid) winner = 1;
      else winner = -1;
      n_checks++;
      if (req0_ready !== (winner == 0) || req1_ready !== (winner == 1)) begin
        n_fail++; $display("FAIL rand_ready[%0d]: r0=%b r1=%b expected %b/%b", c, req0_ready, req1_ready, winner == 0, winner == 1);
      end
      if (m_we) m_busy[m_ad] = 1'b0;
      if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
      if (req0_valid && req1_valid && m_cnt < 65535) m_cnt++;
      m_we = 0;
      if (winner >= 0) begin
        last_winner = winner;
        m_ad = (winner == 0) ? req0_addr : req1_addr;
        m_wd = (winner == 0) ? req0_data : req1_data;
        m_we = (m_ad != 0);
      end
      @(posedge clk); #1;
      n_checks++;
      if (WE3 !== m_we || (m_we && (AD3 !== m_ad || WD3 !== m_wd))) begin
        n_fail++; $display("FAIL rand_wport[%0d]: WE3=%b AD3=%0d WD3=%h expected %b/%0d/%h", c, WE3, AD3, WD3, m_we, m_ad, m_wd);
      end
      n_checks++;
      if (busy_vec !== m_busy || conflict_cnt !== 16'(m_cnt)) begin
        n_fail++; $display("FAIL rand_state[%0d]: busy=%h cnt=%0d expected %h/%0d", c, busy_vec, conflict_cnt, m_busy, m_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    req0_valid = 1; req0_addr = 4; req1_valid = 1; req1_addr = 6;
    repeat (70000) @(posedge clk);
    #1;
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_cnt: cnt=%h expected ffff", conflict_cnt);
    end
    @(posedge clk); #1;
    idle_inputs();
    n_checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold: cnt=%h expected ffff", conflict_cnt);
    end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_single_req0();
    test_contested();
    test_busy_clear();
    test_claim_wins();
    test_addr_zero();
    test_async_reset();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  writeback request (req0 = ALU, req1 = load unit).
REQ-006 SHALL have ports req0_addr / req1_addr  input  ADDRESS_WIDTH  destination register.
REQ-007 SHALL have ports req0_data / req1_data  input  DATA_WIDTH  writeback value.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1  grant; transfer occurs when valid && ready at a rising edge.
REQ-009 SHALL have port claim_valid  input  1  decode reserves a destination register this cycle.
REQ-010 SHALL have port claim_addr  input  ADDRESS_WIDTH  register being reserved.
REQ-011 SHALL have port busy_vec  output  2**ADDRESS_WIDTH  registered per-register pending-write bits.
REQ-012 SHALL have ports WE3  output  1, AD3  output  ADDRESS_WIDTH, WD3  output  DATA_WIDTH  registered write port driving the register file.
REQ-013 SHALL have port conflict_cnt  output  16  saturating count of cycles with both requests valid.

Function
REQ-014 SHALL grant at most one requester per cycle; ready outputs are combinational from valids and the round-robin pointer.
REQ-015 SHALL grant the sole valid requester immediately when only one is valid.
REQ-016 SHALL, when both are valid, grant the requester not granted most recently (1-bit last_grant pointer).
REQ-017 SHALL update last_grant only on a cycle where a transfer occurs.
REQ-018 SHALL deassert both ready outputs when neither requester is valid.
REQ-019 SHALL register the accepted request: transfer at edge N -> WE3=1, AD3/WD3 = accepted addr/data during cycle N+1, so the register file writes at edge N+1.
REQ-020 SHALL drive WE3=0 in any cycle following an edge with no transfer; AD3/WD3 hold their last values.
REQ-021 SHALL accept a request with addr 0 (ready asserted, pointer updated) but SHALL NOT assert WE3 for it.
REQ-022 SHALL set busy_vec[claim_addr] at the edge where claim_valid=1 and claim_addr!=0; claims to register 0 SHALL be ignored.
REQ-023 SHALL clear busy_vec[AD3] at the edge ending a cycle with WE3=1.
REQ-024 SHALL, when a set and a clear target the same register at the same edge, leave the bit set (new claim wins).
REQ-025 SHALL keep busy_vec[0] permanently 0.
REQ-026 SHALL increment conflict_cnt at each edge where req0_valid && req1_valid, saturating at 16'hFFFF.
REQ-027 SHALL NOT require requesters to hold data after the transfer edge.

Reset
REQ-028 SHALL, while rst=1, force WE3=0, AD3=0, WD3=0, busy_vec=0, conflict_cnt=0, last_grant=1 (req0 wins the first contested cycle), independent of clk.
REQ-029 SHALL abandon any accepted-but-unwritten request on reset; no WE3 pulse follows reset deassertion without a new transfer.
REQ-030 SHALL evaluate ready outputs normally on the first edge after rst deasserts.

Verification
REQ-031 SHALL cover: rst pulse mid-cycle with WE3=1 pending -> outputs 0 asynchronously, busy_vec=0, no subsequent write.
REQ-032 SHALL cover: req0 only (addr 5, data 0xDEADBEEF) -> req0_ready=1 same cycle; next cycle WE3=1, AD3=5, WD3=0xDEADBEEF; following cycle WE3=0.
REQ-033 SHALL cover: both valid for 4 cycles after reset (addr 3 vs 7) -> grants req0, req1, req0, req1; WE3 writes 3,7,3,7; conflict_cnt=4.
REQ-034 SHALL cover: claim reg 9, then req1 writes reg 9 -> busy_vec[9]=1 until the edge ending the WE3 cycle, then 0.
REQ-035 SHALL cover: claim reg 9 at the same edge WE3 clears reg 9 -> busy_vec[9] stays 1.
REQ-036 SHALL cover: req0 addr 0 and claim addr 0 -> req0_ready=1, WE3 stays 0, busy_vec[0]=0; 70000 contested cycles -> conflict_cnt holds 0xFFFF.
